// File: rtl/seq_pattern_fsm_pkg.sv
// Shared state encoding for the serial pattern detector and its helpers.
package seq_pattern_pkg;

    localparam int STATE_W = 2;

    // Code 3 is deliberately unused; the FSM treats it as illegal and recovers.
    typedef enum logic [STATE_W-1:0] {
        S_FILL   = 2'd0,
        S_SEARCH = 2'd1,
        S_MATCH  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_pattern_fsm.sv
// Serial PAT_W-bit pattern recogniser: Moore FSM over a shift-register history,
// with optional overlapping matches and a saturating match count.
module seq_pattern_fsm
    import seq_pattern_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               en,
    input  logic               din,
    input  logic               clr,
    output logic               match,
    output logic [CNT_W-1:0]   count,
    output logic [STATE_W-1:0] state
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    state_t           cur, nxt;
    logic [PAT_W-1:0] hist, hist_n, hist_sh;
    logic [FW-1:0]    fill_cnt, fill_n, fill_inc;
    logic             hit;

    // fill_cnt tracks how many real samples are in hist, so reset zeros never match.
    assign hist_sh  = {hist[PAT_W-2:0], din};
    assign fill_inc = (fill_cnt == FULL) ? FULL : fill_cnt + 1'b1;
    assign hit      = (hist_sh == PATTERN) && (fill_inc == FULL);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cur      <= S_FILL;
            hist     <= '0;
            fill_cnt <= '0;
        end else begin
            cur      <= nxt;
            hist     <= hist_n;
            fill_cnt <= fill_n;
        end
    end

    always_comb begin
        nxt    = cur;
        hist_n = hist;
        fill_n = fill_cnt;
        if (clr) begin
            nxt    = S_FILL;
            hist_n = '0;
            fill_n = '0;
        end else begin
            case (cur)
                S_FILL, S_SEARCH: begin
                    if (en) begin
                        hist_n = hist_sh;
                        fill_n = fill_inc;
                        if (hit)
                            nxt = S_MATCH;
                        else if (fill_inc == FULL)
                            nxt = S_SEARCH;
                    end
                end
                S_MATCH: begin
                    if (OVERLAP) begin
                        nxt = S_SEARCH;
                        if (en) begin
                            hist_n = hist_sh;
                            fill_n = fill_inc;
                            if (hit)
                                nxt = S_MATCH;
                        end
                    end else begin
                        // Non-overlapping: the matched bits are spent; restart filling.
                        nxt    = S_FILL;
                        hist_n = en ? PAT_W'(din) : '0;
                        fill_n = en ? FW'(1) : '0;
                    end
                end
                default: begin
                    nxt    = S_FILL;
                    fill_n = '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (clr),
        .inc (!clr && (nxt == S_MATCH)),
        .cnt (count)
    );

    assign match = (cur == S_MATCH);
    assign state = cur;

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Directed bench: three detector configurations driven by one shared stream.
module tb_seq_pattern_fsm;

    logic       Clk, Rst, en, din, clr;
    logic       match_a, match_b, match_c;
    logic [7:0] count_a, count_b;
    logic [1:0] count_c;
    logic [1:0] state_a, state_b, state_c;
    int         errors = 0;
    int         checks = 0;

    seq_pattern_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .en(en), .din(din), .clr(clr),
        .match(match_a), .count(count_a), .state(state_a));

    seq_pattern_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .Clk(Clk), .Rst(Rst), .en(en), .din(din), .clr(clr),
        .match(match_b), .count(count_b), .state(state_b));

    seq_pattern_fsm #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .Clk(Clk), .Rst(Rst), .en(en), .din(din), .clr(clr),
        .match(match_c), .count(count_c), .state(state_c));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input logic e, input logic d, input logic c);
        en = e; din = d; clr = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
        @(posedge Clk); #1;
        chk("rst_state_a", state_a, 0);
        chk("rst_match_a", match_a, 0);
        chk("rst_count_a", count_a, 0);
        chk("rst_count_c", count_c, 0);
        Rst = 1'b0;

        // Overlapping 1011 on 1,0,1,1,0,1,1; non-overlap unit sees the same stream
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        chk("t1_fill_state", state_a, 0);
        chk("t1_fill_match", match_a, 0);
        tick(1, 1, 0);
        chk("t1_m1_a", match_a, 1);
        chk("t1_m1_cnt", count_a, 1);
        chk("t1_m1_b", match_b, 1);
        tick(1, 0, 0);
        chk("t1_b5_a", match_a, 0);
        chk("t1_b5_state_a", state_a, 1);
        chk("t2_b5_b", match_b, 0);
        chk("t2_b5_state_b", state_b, 0);
        tick(1, 1, 0);
        chk("t2_b6_b", match_b, 0);
        tick(1, 1, 0);
        chk("t1_m2_a", match_a, 1);
        chk("t1_m2_cnt", count_a, 2);
        chk("t2_b7_b", match_b, 0);
        tick(1, 1, 0);
        chk("t1_back_search", state_a, 1);
        chk("t1_back_match", match_a, 0);
        chk("t2_b8_b", match_b, 0);
        tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("t2_m11_b", match_b, 1);
        chk("t2_cnt_b", count_b, 2);

        // Non-overlap: 1,0,1,1,1,0,1,1
        tick(1, 1, 1);
        chk("clr_cnt_a", count_a, 0);
        chk("clr_cnt_b", count_b, 0);
        chk("clr_state_b", state_b, 0);
        chk("clr_match_b", match_b, 0);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("t3_m4_b", match_b, 1);
        chk("t3_cnt1_b", count_b, 1);
        tick(1, 1, 0);
        chk("t3_b5_state", state_b, 0);
        chk("t3_b5_match", match_b, 0);
        tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("t3_m8_b", match_b, 1);
        chk("t3_cnt2_b", count_b, 2);

        // en gaps: two idle cycles (with inverted din) after each sampled bit
        tick(0, 0, 1);
        tick(1, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
        tick(1, 0, 0); tick(0, 1, 0); tick(0, 1, 0);
        tick(1, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
        chk("t4_hist_hold", dut_a.hist, 4'b0101);
        chk("t4_gap_state", state_a, 0);
        chk("t4_gap_match", match_a, 0);
        tick(1, 1, 0);
        chk("t4_match", match_a, 1);
        chk("t4_cnt", count_a, 1);
        tick(0, 0, 0);
        chk("t4_exit_match", match_a, 0);
        chk("t4_exit_state", state_a, 1);
        tick(0, 0, 0);
        chk("t4_cnt_hold", count_a, 1);

        // Saturation: PATTERN=11, CNT_W=2, seven 1s
        tick(0, 0, 1);
        tick(1, 1, 0);
        chk("t5_b1_match", match_c, 0);
        for (int k = 2; k <= 7; k++) begin
            tick(1, 1, 0);
            chk($sformatf("t5_b%0d_match", k), match_c, 1);
            chk($sformatf("t5_b%0d_cnt", k), count_c, (k - 1 > 3) ? 3 : k - 1);
        end
        tick(0, 0, 0);
        chk("t5_end_match", match_c, 0);
        chk("t5_end_cnt", count_c, 3);

        // Async reset mid-pattern
        tick(0, 0, 1);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("t6_pre_cnt", count_a, 1);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        #2 Rst = 1'b1;
        #1;
        chk("t6_async_cnt", count_a, 0);
        chk("t6_async_state", state_a, 0);
        chk("t6_async_match", match_a, 0);
        Rst = 1'b0;
        tick(1, 1, 0);
        chk("t6_post_match", match_a, 0);
        chk("t6_post_cnt", count_a, 0);
        chk("t6_post_state", state_a, 0);

        // clr coinciding with the final pattern bit
        tick(0, 0, 1);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        tick(1, 1, 1);
        chk("t7_clr_match", match_a, 0);
        chk("t7_clr_cnt", count_a, 0);
        chk("t7_clr_state", state_a, 0);
        tick(0, 0, 0);
        chk("t7_after_match", match_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_fsm.md
Name: seq_pattern_fsm

Overview:
- Parametrised serial pattern-detector FSM; the successor to the team's fixed two-input 4-state Moore practice machines.
- Samples a 1-bit stream under an enable and detects a PAT_W-bit pattern set by parameter.
- Supports overlapping and non-overlapping detection; keeps a saturating match count.
- Serves as a reusable control/recogniser block in the FSM practice set; drives LEDs/debug via match, count and state.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: target pattern, PAT_W bits wide; MSB is the oldest bit.
- OVERLAP, 1: 1 = bits of a completed match may start the next match; 0 = all bits are consumed by a match.
- CNT_W, 8: width of the match counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; din is consumed only on edges where en=1.
- din  input  1  serial data bit.
- clr  input  1  synchronous clear of history, count and FSM; takes priority over en.
- match  output  1  registered Moore output; high for exactly the cycle(s) the FSM is in S_MATCH.
- count  output  CNT_W  number of matches, saturating at 2^CNT_W-1.
- state  output  2  current state encoding, for debug.

Behaviour:
- Reset (async, Rst=1):
  - state=S_FILL; hist=0; fill_cnt=0; count=0; match=0.
  - Takes effect immediately, mid-operation included; no partial match survives.
- States (2-bit encoding):
  - S_FILL=0: fewer than PAT_W valid bits held.
  - S_SEARCH=1: history full, no match.
  - S_MATCH=2: match asserted.
  - Code 3 is illegal and recovers to S_FILL on the next edge, clearing fill_cnt.
- Datapath, on an edge with en=1 and clr=0:
  - hist_n = {hist[PAT_W-2:0], din}.
  - fill_n = min(fill_cnt+1, PAT_W).
  - hit = (hist_n==PATTERN) && (fill_n==PAT_W).
- Transitions (en=1, clr=0):
  - S_FILL: hit -> S_MATCH; else fill_n==PAT_W -> S_SEARCH; else stay.
  - S_SEARCH: hit -> S_MATCH; else stay.
  - S_MATCH with OVERLAP=1: hit -> S_MATCH (match stays high, count increments again); else -> S_SEARCH.
  - S_MATCH with OVERLAP=0: the previous PAT_W bits are discarded; the new bit is the first fresh bit; fill_cnt=1 -> S_FILL. No match is possible on this edge.
- en=0, clr=0:
  - hist and fill_cnt hold.
  - S_FILL and S_SEARCH hold.
  - S_MATCH exits after one cycle: to S_SEARCH if OVERLAP=1; to S_FILL with fill_cnt=0 if OVERLAP=0.
- Latency: match rises in the cycle immediately after the edge that sampled the final pattern bit (1 cycle).
- Count: increments on the same edge that enters or re-enters S_MATCH; saturates and never wraps.
- match is registered; it is decoded from state S_MATCH and never derived combinationally from din.
- clr=1 (sync, any state, regardless of en):
  - hist=0; fill_cnt=0; count=0; state=S_FILL; match=0 next cycle.
  - A pattern completing on the same edge is not detected and not counted.
- Leading zeros: hist=0 after reset does not count as valid data. PATTERN=0 needs PAT_W real samples before it can match.

Decomposition:
- Package seq_pattern_pkg: state encodings (S_FILL, S_SEARCH, S_MATCH) and the STATE_W=2 constant.
- Sub-module sat_counter: CNT_W param; inputs Clk, Rst, clr, inc; output cnt; saturating. Instantiated once for count.
- FSM and history shift register stay in the top module.

Test Plan:
- PATTERN=1011, OVERLAP=1, en=1, din=1,0,1,1,0,1,1 -> match high in the cycle after bit 4 and after bit 7; count=2; state returns to S_SEARCH.
- Same pattern, OVERLAP=0, din=1,0,1,1,0,1,1 then 1,0,1,1 -> match only after bits 4 and 11; bits 5-7 produce no match; count=2.
- OVERLAP=0, din=1,0,1,1,1,0,1,1 -> matches after bit 4 and bit 8; count=2.
- en gaps: stream 1,0,1,1 with two en=0 cycles between each bit -> single match 1 cycle after the 4th sampled bit; hist unchanged during gaps; count=1.
- CNT_W=2, PATTERN=11, OVERLAP=1, seven consecutive 1s -> match high for 6 consecutive cycles; count saturates at 3, never 0.
- Rst asserted asynchronously mid-pattern (after 1,0,1), then released and 1 sent -> no match; count=0; state=S_FILL. clr on the edge of the 4th bit of 1011 -> match=0; count=0.
